seg7_display_ctrl: RTL

Memory-mapped eight-digit seven-segment display controller directly downstream of the CPU data path. It captures store data addressed to the display I/O region (selected by the I/O decoder's display chip-select) and time-multiplexes the eight hex nibbles onto the board's shared cathode/anode lines. It also provides per-digit enable, per-digit decimal point and global blank controls, plus a registered read-back path for the CPU's load mux.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_hex_decode.sv | 12 +
 rtl/seg7_display_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the memory-mapped seven-segment display controller.
// Hex glyph table, register offsets and CTRL field layout.
package seg7_pkg;

    localparam logic OFS_DATA = 1'b0;
    localparam logic OFS_CTRL = 1'b1;

    localparam int CTRL_EN_LSB = 0;
    localparam int CTRL_DP_LSB = 8;
    localparam int CTRL_BLANK_BIT = 16;
    localparam int CTRL_W = CTRL_BLANK_BIT + 1;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-high g..a glyphs; entry 0 sits in the low bits.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic       blank;
        logic [7:0] dp;
        logic [7:0] en;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{
        blank: 1'b0,
        dp:    8'h00,
        en:    8'hFF
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high g..a glyph decoder.
// The parent inverts the result for the active-low panel.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nib];

endmodule

// File: rtl/seg7_display_ctrl.sv
// Eight-digit multiplexed seven-segment controller with CPU DATA/CTRL
// registers, per-digit enable/dp, global blank and registered read-back.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [31:0] data_q;
    ctrl_t       ctrl_q;
    logic [15:0] div_cnt;
    logic [2:0]  idx;
    logic        wr_en;
    logic        rd_en;
    logic        wrap;
    logic [3:0]  nib;
    logic [6:0]  hex;
    logic        dark;
    logic [7:0]  seg_d;
    logic [7:0]  sel_d;

    assign wr_en = cs & we;
    assign rd_en = cs & ~we;
    assign wrap  = (div_cnt == DIV_LAST);
    assign nib   = data_q[{idx, 2'b00} +: 4];

    seg7_hex_decode u_hex (
        .nib (nib),
        .seg (hex)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            ctrl_q <= CTRL_RST;
        end else if (wr_en) begin
            if (addr == OFS_DATA)
                data_q <= wdata;
            else
                ctrl_q <= ctrl_t'(wdata[CTRL_W-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (wrap) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Disabled slots still burn their time so lit digits keep equal duty.
    always_comb begin
        dark  = ctrl_q.blank | ~ctrl_q.en[idx];
        seg_d = SEG_OFF;
        sel_d = SEG_OFF;
        if (!dark) begin
            sel_d = ~(8'd1 << idx);
            seg_d = {~ctrl_q.dp[idx], ~hex};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_seg <= SEG_OFF;
            o_sel <= SEG_OFF;
        end else begin
            o_seg <= seg_d;
            o_sel <= sel_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rdata <= '0;
        else if (rd_en)
            rdata <= (addr == OFS_CTRL) ? {15'd0, ctrl_q} : data_q;
    end

endmodule
